// File: rtl/timer_arbiter.sv
// Two-port arbiter for the shared timeParameter/timer pair: grants one owner, loads its
// interval code, pulses the timer start and returns expiry (or watchdog timeout) as done.
module timer_arbiter #(
    parameter int unsigned LOAD_CYCLES = 1,
    parameter int unsigned WD_LIMIT    = 20,
    parameter int unsigned WD_WIDTH    = 5
) (
    input  logic       globalClk,
    input  logic       globalReset,
    input  logic       dividerClk,
    input  logic       reprogram,
    input  logic       req0,
    input  logic [1:0] sel0,
    input  logic       req1,
    input  logic [1:0] sel1,
    input  logic       expiredSig,
    output logic [1:0] intervalSel,
    output logic       beginTimer,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       timeout,
    output logic       busy
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [2:0]          LoadLast = 3'(LOAD_CYCLES - 1);
    localparam logic [WD_WIDTH-1:0] WdLast   = WD_WIDTH'(WD_LIMIT - 1);

    logic [2:0]          state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [2:0]          load_cnt_q, load_cnt_d;
    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic [1:0]          sel_q, sel_d;
    logic                begin_q, begin_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                win;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        load_cnt_d = load_cnt_q;
        wd_d       = wd_q;
        sel_d      = sel_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        busy_d     = busy_q;
        begin_d    = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        timeout_d  = 1'b0;
        win        = 1'b0;

        case (state_q)
            StIdle: begin
                if (!reprogram && (req0 || req1)) begin
                    // On a tie, the port that did not finish last wins.
                    win        = (req0 && req1) ? ~last_gnt_q : req1;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    sel_d      = win ? sel1 : sel0;
                    busy_d     = 1'b1;
                    load_cnt_d = 3'd0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (load_cnt_q == LoadLast) begin
                    state_d = StStart;
                    begin_d = 1'b1;
                end else begin
                    load_cnt_d = load_cnt_q + 3'd1;
                end
            end
            StStart: begin
                wd_d    = '0;
                state_d = StRun;
            end
            StRun: begin
                if (expiredSig) begin
                    state_d = StDone;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                end else if (dividerClk && (wd_q == WdLast)) begin
                    state_d   = StDone;
                    done0_d   = gnt0_q;
                    done1_d   = gnt1_q;
                    timeout_d = 1'b1;
                end else if (dividerClk) begin
                    wd_d = wd_q + WD_WIDTH'(1);
                end
            end
            StDone: begin
                last_gnt_d = gnt1_q;
                gnt0_d     = 1'b0;
                gnt1_d     = 1'b0;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        // Abort drops the grant silently; intervalSel and lastGnt are left as they were.
        if (reprogram && (state_q == StLoad || state_q == StStart || state_q == StRun)) begin
            state_d   = StIdle;
            gnt0_d    = 1'b0;
            gnt1_d    = 1'b0;
            busy_d    = 1'b0;
            begin_d   = 1'b0;
            done0_d   = 1'b0;
            done1_d   = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge globalClk) begin
        if (globalReset) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            load_cnt_q <= 3'd0;
            wd_q       <= '0;
            sel_q      <= 2'b00;
            begin_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            load_cnt_q <= load_cnt_d;
            wd_q       <= wd_d;
            sel_q      <= sel_d;
            begin_q    <= begin_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign intervalSel = sel_q;
    assign beginTimer  = begin_q;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: per-scenario tasks plus a done-pulse scoreboard monitor.
module tb_timer_arbiter;

    localparam int unsigned LoadCycles = 1;
    localparam int unsigned WdLimit    = 20;

    logic       globalClk = 1'b0;
    logic       globalReset, dividerClk, reprogram, req0, req1, expiredSig;
    logic [1:0] sel0, sel1;
    logic [1:0] intervalSel;
    logic       beginTimer, gnt0, gnt1, done0, done1, timeout, busy;

    typedef struct packed {
        logic port;
        logic tmo;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned tests    = 0;
    int unsigned fails    = 0;
    int unsigned done_cnt = 0;

    timer_arbiter #(
        .LOAD_CYCLES(LoadCycles),
        .WD_LIMIT   (WdLimit),
        .WD_WIDTH   (5)
    ) dut (
        .globalClk  (globalClk),
        .globalReset(globalReset),
        .dividerClk (dividerClk),
        .reprogram  (reprogram),
        .req0       (req0),
        .sel0       (sel0),
        .req1       (req1),
        .sel1       (sel1),
        .expiredSig (expiredSig),
        .intervalSel(intervalSel),
        .beginTimer (beginTimer),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 globalClk = ~globalClk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim time exceeded, required finish earlier");
        $fatal(1, "timeout");
    end

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge globalClk) begin
        if (!globalReset) begin
            tests++;
            if (gnt0 && gnt1) begin
                fails++;
                $display("FAIL gnt_overlap got gnt0=%0b gnt1=%0b required not both", gnt0, gnt1);
            end
            if (done0 || done1) begin
                done_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done got done0=%0b done1=%0b required none",
                             done0, done1);
                end else begin
                    e = exp_q.pop_front();
                    if ({done1, done0, timeout} !== {e.port, ~e.port, e.tmo}) begin
                        fails++;
                        $display("FAIL done_match got d1/d0/to=%b%b%b required %b%b%b",
                                 done1, done0, timeout, e.port, ~e.port, e.tmo);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge globalClk);
        #1;
    endtask

    task automatic do_reset();
        globalReset = 1'b1;
        dividerClk  = 1'b0;
        reprogram   = 1'b0;
        req0        = 1'b0;
        req1        = 1'b0;
        sel0        = 2'b00;
        sel1        = 2'b00;
        expiredSig  = 1'b0;
        tick();
        tick();
        globalReset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({intervalSel, beginTimer, gnt0, gnt1, done0, done1, timeout, busy} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b required 000000000",
                     {intervalSel, beginTimer, gnt0, gnt1, done0, done1, timeout, busy});
        end
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1;
        sel0 = 2'b10;
        tick();
        tests++;
        if ({gnt0, gnt1, intervalSel, busy, beginTimer} !== 6'b101010) begin
            fails++;
            $display("FAIL single_grant got %b required 101010",
                     {gnt0, gnt1, intervalSel, busy, beginTimer});
        end
        tick();
        tests++;
        if (beginTimer !== 1'b1) begin
            fails++;
            $display("FAIL single_begin got %b required 1", beginTimer);
        end
        tick();
        req0 = 1'b0;
        tests++;
        if (beginTimer !== 1'b0) begin
            fails++;
            $display("FAIL single_begin_pulse got %b required 0", beginTimer);
        end
        expiredSig = 1'b1;
        exp_q.push_back('{port: 1'b0, tmo: 1'b0});
        tick();
        expiredSig = 1'b0;
        tests++;
        if ({done0, gnt0} !== 2'b11) begin
            fails++;
            $display("FAIL single_done got done0/gnt0=%b required 11", {done0, gnt0});
        end
        tick();
        tests++;
        if ({done0, gnt0, busy} !== 3'b000) begin
            fails++;
            $display("FAIL single_release got %b required 000", {done0, gnt0, busy});
        end
    endtask

    task automatic test_round_robin();
        int unsigned n;
        int unsigned start_done;
        logic        exp_port;
        do_reset();
        start_done = done_cnt;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_port = i[0];
            n = 0;
            while (!(gnt0 || gnt1) && n < 10) begin
                tick();
                n++;
            end
            tests++;
            if ({gnt1, gnt0} !== (exp_port ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL rr_grant%0d got gnt1/gnt0=%b%b required port %0d",
                         i, gnt1, gnt0, exp_port);
            end
            tick();
            tick();
            for (int t = 0; t < 3; t++) begin
                dividerClk = 1'b1;
                tick();
            end
            dividerClk = 1'b0;
            expiredSig = 1'b1;
            exp_q.push_back('{port: exp_port, tmo: 1'b0});
            tick();
            expiredSig = 1'b0;
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tests++;
        if (done_cnt - start_done !== 4) begin
            fails++;
            $display("FAIL rr_done_count got %0d required 4", done_cnt - start_done);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            req1 = 1'b1;
            sel1 = 2'b11;
            tick();
            req1 = 1'b0;
            tick();
            tick();
            for (int t = 1; t < int'(WdLimit); t++) begin
                dividerClk = 1'b1;
                tick();
                tests++;
                if (done1 !== 1'b0) begin
                    fails++;
                    $display("FAIL wd_early pass %0d tick %0d got done1=%b required 0",
                             pass, t, done1);
                end
            end
            expiredSig = (pass == 1);
            exp_q.push_back('{port: 1'b1, tmo: (pass == 0)});
            tick();
            dividerClk = 1'b0;
            expiredSig = 1'b0;
            tests++;
            if ({done1, timeout} !== {1'b1, pass == 0}) begin
                fails++;
                $display("FAIL wd_final pass %0d got done1/timeout=%b%b required 1%b",
                         pass, done1, timeout, pass == 0);
            end
            tick();
        end
    endtask

    task automatic test_reprogram();
        do_reset();
        req0 = 1'b1;
        sel0 = 2'b11;
        tick();
        tick();
        tick();
        req1      = 1'b1;
        reprogram = 1'b1;
        tick();
        tests++;
        if ({gnt0, gnt1, busy, done0, intervalSel} !== 6'b000011) begin
            fails++;
            $display("FAIL reprog_abort got %b required 000011",
                     {gnt0, gnt1, busy, done0, intervalSel});
        end
        tick();
        tick();
        tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reprog_hold got %b required 000", {gnt0, gnt1, busy});
        end
        reprogram = 1'b0;
        tick();
        tests++;
        if ({gnt0, gnt1} !== 2'b10) begin
            fails++;
            $display("FAIL reprog_regrant got gnt0/gnt1=%b required 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        expiredSig = 1'b1;
        exp_q.push_back('{port: 1'b0, tmo: 1'b0});
        tick();
        expiredSig = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1;
        sel0 = 2'b01;
        tick();
        globalReset = 1'b1;
        req0        = 1'b0;
        tick();
        globalReset = 1'b0;
        tests++;
        if ({intervalSel, beginTimer, gnt0, gnt1, done0, done1, timeout, busy} !== 9'd0) begin
            fails++;
            $display("FAIL midreset_outputs got %b required 000000000",
                     {intervalSel, beginTimer, gnt0, gnt1, done0, done1, timeout, busy});
        end
        expiredSig = 1'b1;
        tick();
        tests++;
        if ({busy, done0, done1} !== 3'b000) begin
            fails++;
            $display("FAIL idle_expiry got busy/done0/done1=%b required 000",
                     {busy, done0, done1});
        end
        expiredSig = 1'b0;
        req0       = 1'b1;
        tick();
        req0       = 1'b0;
        expiredSig = 1'b1;
        tick();
        expiredSig = 1'b0;
        tests++;
        if ({beginTimer, gnt0, done0} !== 3'b110) begin
            fails++;
            $display("FAIL load_expiry got begin/gnt0/done0=%b required 110",
                     {beginTimer, gnt0, done0});
        end
        tick();
        expiredSig = 1'b1;
        exp_q.push_back('{port: 1'b0, tmo: 1'b0});
        tick();
        expiredSig = 1'b0;
        tick();
    endtask

    task automatic test_sel_hold();
        do_reset();
        req1 = 1'b1;
        sel1 = 2'b01;
        tick();
        req1 = 1'b0;
        tick();
        tick();
        sel1 = 2'b11;
        tick();
        tests++;
        if (intervalSel !== 2'b01) begin
            fails++;
            $display("FAIL sel_hold_run got %b required 01", intervalSel);
        end
        expiredSig = 1'b1;
        exp_q.push_back('{port: 1'b1, tmo: 1'b0});
        tick();
        expiredSig = 1'b0;
        tick();
        tests++;
        if (intervalSel !== 2'b01) begin
            fails++;
            $display("FAIL sel_hold_idle got %b required 01", intervalSel);
        end
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        tests++;
        if (intervalSel !== 2'b11) begin
            fails++;
            $display("FAIL sel_next_grant got %b required 11", intervalSel);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_reprogram();
        test_reset_mid();
        test_sel_hold();
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_done got %0d outstanding required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares the single timeParameter/timer pair between two requesters: port 0 is the main-light FSM and port 1 is a pedestrian/auxiliary phase controller.
- Grants the timer to one requester at a time and drives the interval select into timeParameter.
- Waits for the parameter value to settle, pulses the timer start, then returns expiry to the owner as a one-cycle done pulse.
- Adds a tick-based watchdog and a reprogram abort.

Parameters:
- LOAD_CYCLES, 1: settle cycles between intervalSel update and beginTimer pulse (legal 1..7).
- WD_LIMIT, 20: dividerClk ticks in RUN before a forced timeout; must exceed 15, the max programmable interval.
- WD_WIDTH, 5: watchdog counter width; must hold WD_LIMIT.

Ports:
- globalClk in 1: system clock; all logic on rising edge.
- globalReset in 1: synchronous, active-high reset.
- dividerClk in 1: one-cycle tick enable from clkDivider.
- reprogram in 1: synchronized reprogram level.
- req0 in 1: timer request, port 0 (level).
- sel0 in 2: interval code for port 0, sampled at grant.
- req1 in 1: timer request, port 1 (level).
- sel1 in 2: interval code for port 1, sampled at grant.
- expiredSig in 1: expiry from timer.
- intervalSel out 2: registered interval code to timeParameter.
- beginTimer out 1: one-cycle timer start pulse.
- gnt0 out 1: port 0 owns timer.
- gnt1 out 1: port 1 owns timer.
- done0 out 1: one-cycle completion pulse, port 0.
- done1 out 1: one-cycle completion pulse, port 1.
- timeout out 1: qualifies done; high in the same cycle as done when the watchdog ended the interval.
- busy out 1: high in every state except IDLE.

Behaviour:
- All outputs registered.
- Reset values: intervalSel=00, beginTimer=0, gnt0=gnt1=0, done0=done1=0, timeout=0, busy=0.
- Reset internal state: state=IDLE, lastGnt=1 (so port 0 wins the first tie), load counter=0, watchdog=0.
- globalReset mid-operation returns everything to reset values at the next edge. No done is issued.
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - reprogram=1: stay IDLE, grant nothing.
  - Otherwise, if any req is high, pick the winner: a single requester wins outright; with both high, the port not equal to lastGnt wins (round-robin).
  - Next edge: gnt<winner>=1, intervalSel=sel<winner>, busy=1, load counter cleared, go to LOAD.
- LOAD:
  - Count LOAD_CYCLES cycles, then go to START.
  - The sel inputs are ignored after grant; changes have no effect until the next grant.
- START:
  - beginTimer=1 for exactly this one cycle; watchdog cleared; go to RUN.
- RUN:
  - expiredSig=1: go to DONE with timeout=0.
  - Else, if dividerClk=1 and watchdog==WD_LIMIT-1: go to DONE with timeout=1.
  - Else, if dividerClk=1: watchdog increments.
  - Priority when simultaneous: expiry over watchdog.
  - expiredSig is ignored in every state except RUN.
- DONE:
  - done<owner>=1 and timeout (if set) for one cycle; gnt<owner> stays high in this cycle.
  - lastGnt=owner; next edge returns to IDLE with gnt cleared, done cleared and busy=0.
- Reprogram abort: reprogram=1 in LOAD, START or RUN returns to IDLE at the next edge.
  - gnt is cleared and no done pulse is issued.
  - lastGnt is unchanged.
  - intervalSel holds its last value.
- Req after DONE: a req still high in IDLE is treated as a new request. The requester is expected to drop req on done.
- Req drop: dropping req while granted does not release the grant; only DONE or an abort releases it.
- Latency with LOAD_CYCLES=1, req sampled in IDLE at edge 0:
  - gnt and intervalSel valid after edge 1.
  - beginTimer high after edge 2.
  - RUN from edge 3.
- Latency from expiry: expiry sampled at edge k gives done at k+1 and gnt low at k+2. The earliest next grant is visible at k+3.
- Invariants:
  - gnt0 and gnt1 are never both high.
  - beginTimer is high only in START.
  - done is high only in DONE.

Test Plan:
- Reset, then req0=1 with sel0=10, LOAD_CYCLES=1 -> gnt0 and intervalSel=10 one cycle after the req edge; beginTimer single pulse the cycle after; expiredSig pulse -> done0=1 one cycle later, gnt0=0 the cycle after that.
- req0=req1=1 held continuously, each expiry after 3 ticks -> grants alternate 0,1,0,1; gnt0 and gnt1 never overlap; done count equals grant count.
- Grant port 1, never assert expiredSig, WD_LIMIT=20 -> on the 20th dividerClk tick in RUN, done1=1 with timeout=1; expiredSig and the 20th tick in the same cycle -> timeout=0.
- reprogram=1 during RUN for port 0 -> next cycle state IDLE, gnt0=0, no done0, busy=0; requests held off while reprogram=1; after reprogram drops, port 0 regranted (lastGnt unchanged).
- globalReset asserted during LOAD -> all outputs 0 at the next edge; expiredSig pulses while IDLE or LOAD -> no done, no state change.
- sel1 changed from 01 to 11 during port 1's RUN -> intervalSel stays 01 until the next grant.
